sap_computer: RTL and testbench

- Top-level 8-bit SAP-2-style computer with a 16-bit address space.
- Contains a small CPU with a byte-serial fetch FSM and a microstepped execute phase, a program ROM at 0xF000–0xFFFF, and a data RAM at 0x0000–0x0FFF.
- Instance `sap_computer` is the system top; a bench drives only clock and reset and checks the debug outputs.

---
 rtl/sap_computer.sv | 225 ++++++++++++++++++++++
 tb/tb_sap_computer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_computer.sv
// sap_computer -- 8-bit SAP-2 style computer with a 16-bit address space.
//
// The CPU fetches each instruction one byte at a time. Every byte takes four
// states: LATCH_ADDRESS, READ_BYTE, LATCH_BYTE, CHK_MORE_BYTES. Execution then
// walks through microsteps MS0..MS5. Memory is split into two regions:
//   0x0000-0x0FFF  data RAM (4 KiB, read/write)
//   0xF000-0xFFFF  program ROM (4 KiB, read-only)
// Any other address reads as 0x00. Memory reads are synchronous: the
// address is presented in one cycle and the data appears in the next.
//
// Optional build macro: OUTPUT_PORT_EN
//   defined   : an STA to 0xE000 latches A into out_data
//   undefined : out_data is tied to 0 and writes to 0xE000 are dropped
//
// Ports:
//   clk              system clock, rising edge active
//   reset            asynchronous, active-low reset
//   pc_out           program counter
//   a_out            accumulator A
//   flag_zero_o      Z flag
//   flag_negative_o  N flag
//   mem_address      current bus address (MAR)
//   mem_read         bus read strobe
//   instr_complete   one-cycle pulse in the last execute microstep
//   halted           set once HLT has executed
//   out_data         output-port register
//
// Parameters: ROM_FILE, RAM_FILE (image names), RESET_VECTOR, SP_INIT.
module sap_computer #(
  parameter string       ROM_FILE     = "ROM.hex",
  parameter string       RAM_FILE     = "RAM.hex",
  parameter logic [15:0] RESET_VECTOR = 16'hF000,
  parameter logic [15:0] SP_INIT      = 16'h01FF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] pc_out,
  output logic [7:0]  a_out,
  output logic        flag_zero_o,
  output logic        flag_negative_o,
  output logic [15:0] mem_address,
  output logic        mem_read,
  output logic        instr_complete,
  output logic        halted,
  output logic [7:0]  out_data
);

  localparam logic [7:0] OP_HLT = 8'h01;
  localparam logic [7:0] OP_LDI = 8'h10;
  localparam logic [7:0] OP_LDA = 8'h20;
  localparam logic [7:0] OP_STA = 8'h30;

  typedef enum logic [2:0] {
    STATIC_RESET_VECTOR,
    INIT_STACK_POINTER,
    LATCH_ADDRESS,
    READ_BYTE,
    LATCH_BYTE,
    CHK_MORE_BYTES,
    EXECUTE,
    HALT
  } state_t;

  state_t state, state_next;

  logic [15:0] pc, mar, sp;
  logic [7:0]  a, ir, temp1, temp2;
  logic [7:0]  rdata, rd_mux, a_src;
  logic        flag_z, flag_n, halt_q;
  logic [1:0]  byte_cnt, instr_len;
  logic [2:0]  ms;
  logic        last_ms, a_load, mem_write;

  logic [7:0] rom [0:4095];
  logic [7:0] ram [0:4095];

  // Instruction decode: the byte count and the microstep that ends each
  // instruction. Opcodes that are not recognised behave like a 1-byte NOP.
  always_comb begin
    instr_len = 2'd1;
    last_ms   = (ms == 3'd0);
    case (ir)
      OP_LDI: instr_len = 2'd2;
      OP_LDA: begin
        instr_len = 2'd3;
        last_ms   = (ms == 3'd5);
      end
      OP_STA: begin
        instr_len = 2'd3;
        last_ms   = (ms == 3'd4);
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= STATIC_RESET_VECTOR;
    else        state <= state_next;
  end

  // Next state and bus/control strobes. Byte_cnt already counts the byte that
  // was just latched, so CHK_MORE_BYTES compares it directly with the length.
  always_comb begin
    state_next     = state;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    instr_complete = 1'b0;
    a_load         = 1'b0;
    a_src          = rdata;
    case (state)
      STATIC_RESET_VECTOR: state_next = INIT_STACK_POINTER;
      INIT_STACK_POINTER:  state_next = LATCH_ADDRESS;
      LATCH_ADDRESS:       state_next = READ_BYTE;
      READ_BYTE: begin
        mem_read   = 1'b1;
        state_next = LATCH_BYTE;
      end
      LATCH_BYTE:          state_next = CHK_MORE_BYTES;
      CHK_MORE_BYTES:      state_next = (byte_cnt < instr_len) ? LATCH_ADDRESS : EXECUTE;
      EXECUTE: begin
        if (ir == OP_LDI && ms == 3'd0) begin
          a_load = 1'b1;
          a_src  = temp1;
        end
        if (ir == OP_LDA && ms == 3'd4) mem_read = 1'b1;
        if (ir == OP_LDA && ms == 3'd5) a_load = 1'b1;
        if (ir == OP_STA && ms == 3'd4) mem_write = 1'b1;
        if (last_ms) begin
          instr_complete = 1'b1;
          state_next     = (ir == OP_HLT) ? HALT : LATCH_ADDRESS;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = STATIC_RESET_VECTOR;
    endcase
  end

  // CPU datapath registers. LDA/STA assemble the operand address in MAR one
  // byte at a time (MS1 low, MS3 high); MAR therefore drives the bus in MS4.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= 16'h0000;
      sp       <= SP_INIT;
      mar      <= 16'h0000;
      a        <= 8'h00;
      ir       <= 8'h00;
      temp1    <= 8'h00;
      temp2    <= 8'h00;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      halt_q   <= 1'b0;
      byte_cnt <= 2'd0;
      ms       <= 3'd0;
    end else begin
      case (state)
        STATIC_RESET_VECTOR: pc <= RESET_VECTOR;
        INIT_STACK_POINTER:  sp <= SP_INIT;
        LATCH_ADDRESS:       mar <= pc;
        LATCH_BYTE: begin
          case (byte_cnt)
            2'd0:    ir    <= rdata;
            2'd1:    temp1 <= rdata;
            default: temp2 <= rdata;
          endcase
          byte_cnt <= byte_cnt + 2'd1;
          pc       <= pc + 16'd1;
        end
        CHK_MORE_BYTES: ms <= 3'd0;
        EXECUTE: begin
          ms <= ms + 3'd1;
          if ((ir == OP_LDA || ir == OP_STA) && ms == 3'd1) mar[7:0]  <= temp1;
          if ((ir == OP_LDA || ir == OP_STA) && ms == 3'd3) mar[15:8] <= temp2;
          if (ir == OP_HLT) halt_q <= 1'b1;
          if (last_ms) byte_cnt <= 2'd0;
        end
        default: ;
      endcase
      if (a_load) begin
        a      <= a_src;
        flag_z <= (a_src == 8'h00);
        flag_n <= a_src[7];
      end
    end
  end

  // Address decode for reads; unmapped space reads as zero.
  always_comb begin
    rd_mux = 8'h00;
    if (mar[15:12] == 4'hF)      rd_mux = rom[mar[11:0]];
    else if (mar[15:12] == 4'h0) rd_mux = ram[mar[11:0]];
  end

  // Registered read data: valid the cycle after the address.
  always_ff @(posedge clk) begin
    rdata <= rd_mux;
  end

  // RAM write port. Kept as a plain clocked block because the array is also
  // written directly from outside for preloading.
  always @(posedge clk) begin
    if (mem_write && mar[15:12] == 4'h0) ram[mar[11:0]] <= a;
  end

`ifdef OUTPUT_PORT_EN
  logic [7:0] out_q;

  // Output port: a store to 0xE000 latches A until the next such store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             out_q <= 8'h00;
    else if (mem_write && mar == 16'hE000)  out_q <= a;
  end
  assign out_data = out_q;
`else
  assign out_data = 8'h00;
`endif

  assign pc_out          = pc;
  assign a_out           = a;
  assign flag_zero_o     = flag_z;
  assign flag_negative_o = flag_n;
  assign mem_address     = mar;
  assign halted          = halt_q;

endmodule

// File: tb/tb_sap_computer.sv
// tb_sap_computer -- self-checking bench for sap_computer.
// Programs are placed directly into the DUT memories (no image files), the
// CPU runs until HLT, and results are compared against a table of
// hand-derived results and an instruction-level reference interpreter.
module tb_sap_computer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_out, mem_address;
  logic [7:0]  a_out, out_data;
  logic        flag_zero_o, flag_negative_o, mem_read, instr_complete, halted;

  int vectors     = 0;
  int miscompares = 0;

`ifdef OUTPUT_PORT_EN
  localparam bit PORT_EN = 1'b1;
`else
  localparam bit PORT_EN = 1'b0;
`endif

  sap_computer #(
    .ROM_FILE     (""),
    .RAM_FILE     (""),
    .RESET_VECTOR (16'hF000),
    .SP_INIT      (16'h01FF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_out          (pc_out),
    .a_out           (a_out),
    .flag_zero_o     (flag_zero_o),
    .flag_negative_o (flag_negative_o),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .instr_complete  (instr_complete),
    .halted          (halted),
    .out_data        (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] prog;
    int          len;
    logic [15:0] init_addr;
    logic [7:0]  init_val;
    logic [15:0] chk_addr;
    logic [7:0]  chk_val;
    logic [7:0]  exp_a;
    logic        exp_z;
    logic        exp_n;
    logic [15:0] exp_pc;
    logic [7:0]  exp_out;
  } vec_t;

  typedef struct {
    logic [7:0]  a;
    logic        z;
    logic        n;
    logic [15:0] pc;
  } step_t;

  vec_t        vecs [6];
  step_t       trace [$];
  logic [7:0]  img_rom [0:4095];
  logic [7:0]  img_ram [0:4095];
  logic [7:0]  mdl_ram [0:4095];
  int          exp_halt_edge;
  logic [7:0]  exp_out;
  int          prog_pos;

  task automatic check_output(input string what, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, actual, expected);
    end
  endtask

  task automatic clear_images();
    for (int i = 0; i < 4096; i++) begin
      img_rom[i] = 8'h00;
      img_ram[i] = 8'h00;
    end
    prog_pos = 0;
  endtask

  task automatic emit(input logic [7:0] b);
    img_rom[prog_pos] = b;
    prog_pos++;
  endtask

  task automatic put_prog(input logic [95:0] prog, input int len);
    for (int i = 0; i < len; i++) emit(prog[95-8*i -: 8]);
  endtask

  // Static task so the loop index may index a non-blocking target.
  task load_images();
    for (int i = 0; i < 4096; i++) begin
      dut.rom[i] <= img_rom[i];
      dut.ram[i] <= img_ram[i];
    end
  endtask

  // Reference model: plain instruction-level interpreter over the images.
  function automatic logic [7:0] model_rd(input logic [15:0] addr);
    if (addr[15:12] == 4'hF) return img_rom[addr[11:0]];
    if (addr[15:12] == 4'h0) return mdl_ram[addr[11:0]];
    return 8'h00;
  endfunction

  task automatic run_model();
    logic [15:0] pc, ad;
    logic [7:0]  a, op, b1, b2;
    logic        z, n;
    int          len, steps, cycles;
    step_t       s;
    pc = 16'hF000; a = 8'h00; z = 1'b0; n = 1'b0; cycles = 2;
    exp_out = 8'h00;
    trace.delete();
    for (int i = 0; i < 4096; i++) mdl_ram[i] = img_ram[i];
    for (int k = 0; k < 100; k++) begin
      op = model_rd(pc);
      b1 = model_rd(pc + 16'd1);
      b2 = model_rd(pc + 16'd2);
      ad = {b2, b1};
      case (op)
        8'h10:   begin len = 2; steps = 1; end
        8'h20:   begin len = 3; steps = 6; end
        8'h30:   begin len = 3; steps = 5; end
        default: begin len = 1; steps = 1; end
      endcase
      pc = pc + 16'(len);
      if (op == 8'h10 || op == 8'h20) begin
        a = (op == 8'h10) ? b1 : model_rd(ad);
        z = (a == 8'h00);
        n = a[7];
      end
      if (op == 8'h30) begin
        if (ad[15:12] == 4'h0) mdl_ram[ad[11:0]] = a;
        if (PORT_EN && ad == 16'hE000) exp_out = a;
      end
      cycles += 4 * len + steps;
      s.a = a; s.z = z; s.n = n; s.pc = pc;
      trace.push_back(s);
      if (op == 8'h01) break;
    end
    exp_halt_edge = cycles;
  endtask

  // Hold reset, load the memories, check the reset state, release on a
  // falling edge so the next rising edge is the first one after release.
  task automatic apply_stimulus();
    reset = 1'b0;
    load_images();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_output("reset pc", pc_out, 16'h0000);
    check_output("reset a", a_out, 8'h00);
    check_output("reset flags", {flag_zero_o, flag_negative_o}, 2'b00);
    check_output("reset mem_address", mem_address, 16'h0000);
    check_output("reset strobes", {mem_read, instr_complete, halted}, 3'b000);
    check_output("reset out_data", out_data, 8'h00);
    reset = 1'b1;
  endtask

  // Run the current images to HLT, comparing the architectural state after
  // every instruction and the exact cycle on which halted rises.
  task automatic run_check(input string tag, input int budget);
    int          idx, edge_n;
    bit          prev_ic, done;
    logic [15:0] pc_h;
    idx = 0; edge_n = 0; prev_ic = 1'b0; done = 1'b0;
    run_model();
    apply_stimulus();
    while (!done && edge_n < budget) begin
      @(posedge clk); #1;
      edge_n++;
      if (prev_ic) begin
        if (idx < trace.size()) begin
          check_output($sformatf("%s step%0d a", tag, idx), a_out, trace[idx].a);
          check_output($sformatf("%s step%0d zn", tag, idx), {flag_zero_o, flag_negative_o},
                       {trace[idx].z, trace[idx].n});
          check_output($sformatf("%s step%0d pc", tag, idx), pc_out, trace[idx].pc);
        end else begin
          check_output($sformatf("%s instr count", tag), idx + 1, trace.size());
        end
        idx++;
      end
      prev_ic = instr_complete;
      if (halted) begin
        check_output($sformatf("%s halt cycle", tag), edge_n, exp_halt_edge);
        done = 1'b1;
      end
    end
    check_output($sformatf("%s halted within budget", tag), halted, 1'b1);
    check_output($sformatf("%s instructions completed", tag), idx, trace.size());
    pc_h = pc_out;
    repeat (3) @(posedge clk);
    #1;
    check_output($sformatf("%s halt holds", tag), {halted, instr_complete, pc_out}, {2'b10, pc_h});
    check_output($sformatf("%s out_data", tag), out_data, exp_out);
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return 16'h0010 + 16'($urandom_range(0, 7));
      3:       return 16'hE000;
      4:       return 16'h5000 + 16'($urandom_range(0, 255));
      default: return 16'hF000 + 16'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [7:0] pick_unknown();
    case ($urandom_range(0, 3))
      0:       return 8'h02;
      1:       return 8'h3F;
      2:       return 8'h80;
      default: return 8'hFF;
    endcase
  endfunction

  initial begin
    logic [15:0] ad;
    reset = 1'b0;

    vecs[0] = '{96'h20_00_02_01_00_00_00_00_00_00_00_00, 4, 16'h0200, 8'h55, 16'h0200, 8'h55,
                8'h55, 1'b0, 1'b0, 16'hF004, 8'h00};
    vecs[1] = '{96'h10_00_10_80_01_00_00_00_00_00_00_00, 5, 16'h0FFF, 8'h00, 16'h0FFF, 8'h00,
                8'h80, 1'b0, 1'b1, 16'hF005, 8'h00};
    vecs[2] = '{96'h10_3C_30_10_00_20_10_00_01_00_00_00, 9, 16'h0FFF, 8'h00, 16'h0010, 8'h3C,
                8'h3C, 1'b0, 1'b0, 16'hF009, 8'h00};
    vecs[3] = '{96'h10_A5_30_00_E0_01_00_00_00_00_00_00, 6, 16'h0FFF, 8'h00, 16'h0000, 8'h00,
                8'hA5, 1'b0, 1'b1, 16'hF006, PORT_EN ? 8'hA5 : 8'h00};
    vecs[4] = '{96'hFF_01_00_00_00_00_00_00_00_00_00_00, 2, 16'h0FFF, 8'h00, 16'h0FFF, 8'h00,
                8'h00, 1'b0, 1'b0, 16'hF002, 8'h00};
    vecs[5] = '{96'h10_7F_20_00_50_01_00_00_00_00_00_00, 6, 16'h0FFF, 8'h00, 16'h0FFF, 8'h00,
                8'h00, 1'b1, 1'b0, 16'hF006, 8'h00};

    // Table-driven programs with hand-derived final state.
    for (int v = 0; v < 6; v++) begin
      clear_images();
      put_prog(vecs[v].prog, vecs[v].len);
      img_ram[vecs[v].init_addr[11:0]] = vecs[v].init_val;
      run_check($sformatf("vec%0d", v), 200);
      check_output($sformatf("vec%0d final a", v), a_out, vecs[v].exp_a);
      check_output($sformatf("vec%0d final zn", v), {flag_zero_o, flag_negative_o},
                   {vecs[v].exp_z, vecs[v].exp_n});
      check_output($sformatf("vec%0d final pc", v), pc_out, vecs[v].exp_pc);
      check_output($sformatf("vec%0d out_data", v), out_data, vecs[v].exp_out);
      check_output($sformatf("vec%0d ram", v), dut.ram[vecs[v].chk_addr[11:0]], vecs[v].chk_val);
    end

    // Fetch and LDA execute timing, cycle by cycle.
    clear_images();
    put_prog(vecs[0].prog, vecs[0].len);
    img_ram[12'h200] = 8'h55;
    apply_stimulus();
    check_output("pre-fetch pc", pc_out, 16'h0000);
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      case (e)
        1:  check_output("vector load pc", pc_out, 16'hF000);
        2:  check_output("first latch_address", {mem_read, pc_out}, {1'b0, 16'hF000});
        3:  check_output("read byte1", {mem_read, mem_address}, {1'b1, 16'hF000});
        7:  check_output("read byte2", {mem_read, mem_address, pc_out}, {1'b1, 16'hF001, 16'hF001});
        11: check_output("read byte3", {mem_read, mem_address}, {1'b1, 16'hF002});
        18: check_output("lda operand read", {mem_read, mem_address}, {1'b1, 16'h0200});
        19: check_output("lda complete pulse", {instr_complete, mem_read}, 2'b10);
        20: check_output("lda result", {instr_complete, a_out}, {1'b0, 8'h55});
        default: ;
      endcase
    end

    // Reset during LATCH_BYTE of byte 2 of the STA in the round-trip program.
    clear_images();
    put_prog(vecs[2].prog, vecs[2].len);
    apply_stimulus();
    repeat (17) @(posedge clk);
    #1;
    check_output("before abort", {a_out, mem_address}, {8'h3C, 16'hF003});
    reset = 1'b0;
    #1;
    check_output("abort pc", pc_out, 16'h0000);
    check_output("abort a", a_out, 8'h00);
    check_output("abort mem_address", mem_address, 16'h0000);
    check_output("abort strobes", {mem_read, instr_complete, halted, flag_zero_o, flag_negative_o}, 5'b0);
    repeat (2) @(posedge clk);
    #1;
    check_output("abort held", {pc_out, mem_read}, 17'h0);
    run_check("refetch", 200);
    check_output("refetch a", a_out, vecs[2].exp_a);
    check_output("refetch pc", pc_out, vecs[2].exp_pc);
    check_output("refetch ram", dut.ram[12'h010], vecs[2].chk_val);

    // Random programs against the reference interpreter.
    for (int p = 0; p < 8; p++) begin
      clear_images();
      for (int k = 0; k < 8; k++) img_ram[16 + k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 10; k++) begin
        ad = pick_addr();
        case ($urandom_range(0, 4))
          0: emit(8'h00);
          1: emit(pick_unknown());
          2: begin
            emit(8'h10);
            emit(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
          end
          3: begin emit(8'h20); emit(ad[7:0]); emit(ad[15:8]); end
          default: begin emit(8'h30); emit(ad[7:0]); emit(ad[15:8]); end
        endcase
      end
      emit(8'h01);
      run_check($sformatf("rand%0d", p), 400);
      for (int k = 0; k < 8; k++)
        check_output($sformatf("rand%0d ram[%0d]", p, 16 + k), dut.ram[16 + k], mdl_ram[16 + k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
